// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the core run controller: state encoding and hold-counter sizing.
package run_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE       = 2'd0,
    RESET_HOLD = 2'd1,
    RUN        = 2'd2,
    DONE       = 2'd3
  } run_state_t;

  function automatic int hold_cnt_w(input int reset_cycles);
    return $clog2(reset_cycles + 1);
  endfunction

endpackage

// File: rtl/run_controller.sv
// Sequences core reset, gates execution and counts run cycles until all cores halt or the budget expires.
// All outputs are registered; status is held in DONE until the next start or reset.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int NUM_CORES    = 1,
  parameter int RESET_CYCLES = 4,
  parameter int MAX_CYCLES   = 32,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_CORES-1:0] halt,
  output logic                 core_reset,
  output logic                 run_en,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [NUM_CORES-1:0] halted_mask,
  output logic                 done,
  output logic                 timeout
);

  localparam int                HOLD_W    = hold_cnt_w(RESET_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(MAX_CYCLES - 1);

  if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
    $error("run_controller: RESET_CYCLES must be at least 1");
  end
  if (MAX_CYCLES < 1) begin : g_bad_max_cycles
    $error("run_controller: MAX_CYCLES must be at least 1");
  end
  if (longint'(MAX_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
    $error("run_controller: MAX_CYCLES must be below 2**CNT_W");
  end

  run_state_t        state, next_state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              all_halt;
  logic              budget_end;
  logic              core_reset_d;
  logic              run_en_d;

  always_comb begin
    all_halt     = &(halted_mask | halt);
    budget_end   = (cycle_count == LAST_CNT);
    next_state   = state;
    case (state)
      IDLE, DONE: begin
        if (start) next_state = RESET_HOLD;
      end
      RESET_HOLD: begin
        if (abort)                next_state = IDLE;
        else if (hold_cnt == '0)  next_state = RUN;
      end
      RUN: begin
        // abort beats halt, and halt beats budget expiry
        if (abort)                     next_state = IDLE;
        else if (all_halt || budget_end) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
    core_reset_d = (next_state == IDLE) || (next_state == RESET_HOLD);
    run_en_d     = (next_state == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      cycle_count <= '0;
      halted_mask <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      core_reset  <= 1'b1;
      run_en      <= 1'b0;
    end else begin
      state      <= next_state;
      core_reset <= core_reset_d;
      run_en     <= run_en_d;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            hold_cnt    <= HOLD_LOAD;
            cycle_count <= '0;
            halted_mask <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        RESET_HOLD: begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        end
        RUN: begin
          // the aborting cycle still counts as an elapsed run cycle
          cycle_count <= cycle_count + 1'b1;
          halted_mask <= halted_mask | halt;
          if (next_state == DONE) begin
            done    <= 1'b1;
            timeout <= ~all_halt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Randomised and directed stimulus for run_controller against a cycle-offset reference model.
module tb_run_controller;

  localparam int NC = 2;
  localparam int RC = 3;
  localparam int MC = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NC-1:0] halt = '0;
  logic          core_reset, run_en, done, timeout;
  logic [CW-1:0] cycle_count;
  logic [NC-1:0] halted_mask;

  run_controller #(
    .NUM_CORES(NC), .RESET_CYCLES(RC), .MAX_CYCLES(MC), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .halt(halt),
    .core_reset(core_reset), .run_en(run_en), .cycle_count(cycle_count),
    .halted_mask(halted_mask), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit      cr;
    bit      re;
    bit      dn;
    bit      to;
    int      cnt;
    bit [NC-1:0] mask;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: mode 0 idle, 1 holding reset, 2 running, 3 finished.
  int          m_mode = 0;
  int          m_held = 0;
  int          m_runs = 0;
  bit [NC-1:0] m_mask = '0;
  bit          m_done = 0;
  bit          m_to   = 0;

  task automatic model_step(input bit r, input bit s, input bit a, input bit [NC-1:0] h);
    if (r) begin
      m_mode = 0; m_runs = 0; m_mask = '0; m_done = 0; m_to = 0;
    end else if (m_mode == 0 || m_mode == 3) begin
      if (s) begin
        m_mode = 1; m_held = 0; m_runs = 0; m_mask = '0; m_done = 0; m_to = 0;
      end
    end else if (m_mode == 1) begin
      m_held++;
      if (a) m_mode = 0;
      else if (m_held == RC) m_mode = 2;
    end else begin
      m_runs++;
      m_mask = m_mask | h;
      if (a) m_mode = 0;
      else if (m_mask == {NC{1'b1}}) begin m_mode = 3; m_done = 1; m_to = 0; end
      else if (m_runs == MC) begin m_mode = 3; m_done = 1; m_to = 1; end
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit a, input bit [NC-1:0] h);
    exp_t e;
    @(negedge clk);
    reset = r; start = s; abort = a; halt = h;
    model_step(r, s, a, h);
    e.cr = (m_mode <= 1);
    e.re = (m_mode == 2);
    e.dn = m_done;
    e.to = m_to;
    e.cnt = m_runs;
    e.mask = m_mask;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("core_reset", int'(core_reset), int'(e.cr));
        chk("run_en", int'(run_en), int'(e.re));
        chk("done", int'(done), int'(e.dn));
        chk("timeout", int'(timeout), int'(e.to));
        chk("cycle_count", int'(cycle_count), e.cnt);
        chk("halted_mask", int'(halted_mask), int'(e.mask));
      end
    end
  end

  initial begin : driver
    bit [NC-1:0] h;
    repeat (2) cyc(1, 0, 0, '0);
    repeat (3) cyc(0, 0, 1, 2'b11);

    // budget expiry, with starts ignored during hold and run
    cyc(0, 1, 0, '0);
    cyc(0, 1, 0, '0);
    repeat (RC - 1) cyc(0, 0, 0, '0);
    for (int k = 1; k <= MC; k++) cyc(0, (k == 2), 0, '0);
    repeat (3) cyc(0, 0, 0, 2'b11);

    // staggered halts finish before the budget
    cyc(0, 1, 0, '0);
    repeat (RC) cyc(0, 0, 0, '0);
    for (int k = 1; k <= 7; k++) cyc(0, 0, 0, (k == 3) ? 2'b01 : (k == 7) ? 2'b10 : 2'b00);
    repeat (2) cyc(0, 0, 0, '0);

    // halt on the last budget cycle wins over expiry
    cyc(0, 1, 0, '0);
    repeat (RC) cyc(0, 0, 0, '0);
    for (int k = 1; k <= MC; k++) cyc(0, 0, 0, (k == MC) ? 2'b11 : 2'b00);
    cyc(0, 0, 0, '0);

    // abort with halt, then restart clears status
    cyc(0, 1, 1, '0);
    repeat (RC) cyc(0, 0, 0, '0);
    for (int k = 1; k <= 5; k++) cyc(0, 0, (k == 5), (k == 5) ? 2'b11 : 2'b00);
    repeat (2) cyc(0, 0, 0, '0);
    cyc(0, 1, 0, '0);
    cyc(0, 0, 1, '0);
    cyc(0, 0, 0, '0);

    // reset mid-run
    cyc(0, 1, 0, '0);
    repeat (RC) cyc(0, 0, 0, '0);
    for (int k = 1; k <= 6; k++) cyc((k == 6), 0, 0, '0);
    repeat (2) cyc(0, 0, 0, '0);

    for (int i = 0; i < 3000; i++) begin
      h = ($urandom_range(0, 5) == 0) ? NC'($urandom) : '0;
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 29) == 0), h);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
